hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It detects load-use and multiply/divide hazards for the instruction in ID and resolves taken branches arriving from EX. It drives the PC write enable, the IF/ID enable and flush, and the ID/EX bubble insert. It works alongside the forwarding unit: forwarding covers every RAW case except a load in EX, which this block stalls for exactly one cycle.

---
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 79 +++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX hazard inputs and pipeline control outputs of hazard_ctrl
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_md_op;
  logic             id_md_read;
  logic [4:0]       ex_wn;
  logic             ex_memread;
  logic             ex_br_taken;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_md_read,
    output ex_wn, ex_memread, ex_br_taken,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_op, id_md_read,
    input  ex_wn, ex_memread, ex_br_taken,
    output pc_en, ifid_en, ifid_flush, idex_bubble, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use and mult/div stall, taken-branch flush for the 5-stage core
// Stall cycle counter is built only when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  logic [7:0] md_cnt;
  logic       md_busy;
  logic       lu;
  logic       mdh;
  logic       stall;
  logic       flush;
  logic       issue;

  assign md_busy    = (md_cnt != 8'd0);
  assign hz.md_busy = md_busy;

  always_comb begin
    lu    = hz.ex_memread && (hz.ex_wn != 5'd0) &&
            ((hz.id_use_rs && (hz.ex_wn == hz.id_rs)) ||
             (hz.id_use_rt && (hz.ex_wn == hz.id_rt)));
    mdh   = md_busy && (hz.id_md_read || hz.id_md_op);
    flush = hz.ex_br_taken;
    stall = (lu || mdh) && !flush;
    issue = hz.id_md_op && !stall && !flush;
  end

  // Flush beats stall: the wrong-path ID instruction's hazards are irrelevant.
  always_comb begin
    hz.pc_en       = 1'b1;
    hz.ifid_en     = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    if (flush) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (stall) begin
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      hz.idex_bubble = 1'b1;
    end
    if (!rst) begin
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt <= 8'd0;
    end else if (issue) begin
      md_cnt <= 8'(MD_LAT);
    end else if (md_busy) begin
      md_cnt <= md_cnt - 8'd1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (stall && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = cnt;
`else
  assign hz.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_cnt;

  hazard_ctrl_if #(.CNT_W(8)) hz ();
  hazard_ctrl_if #(.CNT_W(3)) hs ();

  hazard_ctrl #(.MD_LAT(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  hazard_ctrl #(.MD_LAT(12), .CNT_W(3)) u_sat (
    .clk (clk),
    .rst (rst),
    .hz  (hs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wn;
    logic       use_rs;
    logic       use_rt;
    logic       memread;
    logic       md_read;
    logic       br;
    logic       pc;
    logic       en;
    logic       fl;
    logic       bub;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_ctl(input string name, input logic pc, input logic en,
                         input logic fl, input logic bub);
    chk({name, "_pc_en"}, 32'(hz.pc_en), 32'(pc));
    chk({name, "_ifid_en"}, 32'(hz.ifid_en), 32'(en));
    chk({name, "_ifid_flush"}, 32'(hz.ifid_flush), 32'(fl));
    chk({name, "_idex_bubble"}, 32'(hz.idex_bubble), 32'(bub));
  endtask

  task automatic set_idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
    hz.id_md_op = 1'b0; hz.id_md_read = 1'b0;
    hz.ex_wn = 5'd0; hz.ex_memread = 1'b0; hz.ex_br_taken = 1'b0;
    hs.id_rs = 5'd0; hs.id_rt = 5'd0; hs.id_use_rs = 1'b0; hs.id_use_rt = 1'b0;
    hs.id_md_op = 1'b0; hs.id_md_read = 1'b0;
    hs.ex_wn = 5'd0; hs.ex_memread = 1'b0; hs.ex_br_taken = 1'b0;
  endtask

  // Advance one clock on the main DUT; stalled tells the counter model what the cycle was.
  task automatic step(input bit stalled);
    @(posedge clk);
    #1;
    if (CNT_ON && stalled && exp_cnt < 255) exp_cnt++;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_cnt = 0;
    rst     = 1'b0;
    set_idle();

    //                rs   rt   wn  urs urt mrd mdr br   pc en fl bub
    vt[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0,   1, 1, 0, 0};
    vt[1]  = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 0, 0,   0, 0, 0, 1};
    vt[2]  = '{5'd8, 5'd9, 5'd9, 1, 1, 1, 0, 0,   0, 0, 0, 1};
    vt[3]  = '{5'd8, 5'd0, 5'd8, 0, 0, 1, 0, 0,   1, 1, 0, 0};
    vt[4]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0,   1, 1, 0, 0};
    vt[5]  = '{5'd8, 5'd8, 5'd8, 1, 1, 0, 0, 0,   1, 1, 0, 0};
    vt[6]  = '{5'd9, 5'd10, 5'd8, 1, 1, 1, 0, 0,  1, 1, 0, 0};
    vt[7]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,   1, 1, 1, 1};
    vt[8]  = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 0, 1,   1, 1, 1, 1};
    vt[9]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0,   1, 1, 0, 0};
    vt[10] = '{5'd3, 5'd31, 5'd31, 1, 1, 1, 0, 0, 0, 0, 0, 1};

    // Reset state
    @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_md_busy", 32'(hz.md_busy), 32'd0);
    chk("reset_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_ctl("release", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);

    for (int i = 0; i < 11; i++) begin
      hz.id_rs = vt[i].rs; hz.id_rt = vt[i].rt; hz.ex_wn = vt[i].wn;
      hz.id_use_rs = vt[i].use_rs; hz.id_use_rt = vt[i].use_rt;
      hz.ex_memread = vt[i].memread; hz.id_md_read = vt[i].md_read;
      hz.ex_br_taken = vt[i].br; hz.id_md_op = 1'b0;
      @(negedge clk);
      chk_ctl($sformatf("vec%0d", i), vt[i].pc, vt[i].en, vt[i].fl, vt[i].bub);
      step(!vt[i].pc);
    end
    set_idle();
    chk("table_stall_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));

    // Load-use: one stall, then the load moves to MEM and the pipe runs
    hz.ex_memread = 1'b1; hz.ex_wn = 5'd8; hz.id_rs = 5'd8; hz.id_use_rs = 1'b1;
    @(negedge clk);
    chk_ctl("lu_stall", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    hz.ex_memread = 1'b0; hz.ex_wn = 5'd0;
    @(negedge clk);
    chk_ctl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));
    step(1'b0);
    set_idle();

    // Mult/div with MD_LAT=4: busy cycles 1..4, read proceeds at cycle 5
    hz.id_md_op = 1'b1;
    @(negedge clk);
    chk_ctl("md_issue", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("md_issue_busy", 32'(hz.md_busy), 32'd0);
    step(1'b0);
    hz.id_md_op = 1'b0; hz.id_md_read = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("md_busy_c%0d", c), 32'(hz.md_busy), 32'd1);
      chk($sformatf("md_pc_en_c%0d", c), 32'(hz.pc_en), 32'd0);
      chk($sformatf("md_bubble_c%0d", c), 32'(hz.idex_bubble), 32'd1);
      step(1'b1);
    end
    @(negedge clk);
    chk("md_busy_c5", 32'(hz.md_busy), 32'd0);
    chk_ctl("md_read_c5", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("md_stall_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));
    step(1'b0);
    set_idle();

    // Flush beats load-use, blocks md issue, and is not counted
    hz.ex_memread = 1'b1; hz.ex_wn = 5'd8; hz.id_rs = 5'd8; hz.id_use_rs = 1'b1;
    hz.ex_br_taken = 1'b1; hz.id_md_op = 1'b1;
    @(negedge clk);
    chk_ctl("flush_prio", 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0);
    set_idle();
    @(negedge clk);
    chk("flush_md_busy", 32'(hz.md_busy), 32'd0);
    chk("flush_stall_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));
    step(1'b0);

    // Asynchronous reset two cycles after an md issue
    hz.id_md_op = 1'b1;
    step(1'b0);
    hz.id_md_op = 1'b0;
    step(1'b0);
    chk("rst_pre_busy", 32'(hz.md_busy), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    chk("rst_async_busy", 32'(hz.md_busy), 32'd0);
    chk("rst_async_cnt", 32'(hz.stall_cnt), 32'd0);
    chk_ctl("rst_async", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_ctl("rst_release", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_release_busy", 32'(hz.md_busy), 32'd0);
    step(1'b0);

    // Saturation on the 3-bit counter instance: ten back-to-back mdh stalls
    hs.id_md_op = 1'b1;
    @(posedge clk);
    #1;
    hs.id_md_op = 1'b0; hs.id_md_read = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("sat_pc_en_c%0d", c), 32'(hs.pc_en), 32'd0);
      @(posedge clk);
      #1;
      if (c == 3) chk("sat_cnt_3", 32'(hs.stall_cnt), CNT_ON ? 32'd3 : 32'd0);
    end
    chk("sat_cnt_10", 32'(hs.stall_cnt), CNT_ON ? 32'd7 : 32'd0);
    chk("sat_busy", 32'(hs.md_busy), 32'd1);
    set_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
